// File: rtl/multi_cycle_issue_scheduler.sv
// Issue-side controller for a fixed-latency, non-stallable multi-cycle ALU and a
// single-cycle ALU: hazard blocking, writeback-port arbitration and op select.
module multi_cycle_issue_scheduler #(
    parameter int unsigned MC_LATENCY = 3,
    parameter int unsigned REG_BITS   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    input  logic                issue_multi_i,
    input  logic [5:0]          issue_op_i,
    input  logic [REG_BITS-1:0] issue_dest_i,
    input  logic [REG_BITS-1:0] issue_src1_i,
    input  logic [REG_BITS-1:0] issue_src2_i,
    output logic                issue_ready_o,
    output logic [5:0]          mc_operation_o,
    output logic                wb_valid_o,
    output logic [REG_BITS-1:0] wb_dest_o,
    output logic                wb_from_multi_o,
    output logic                busy_o
);

    localparam int unsigned TOP      = MC_LATENCY - 1;
    localparam int unsigned CONFLICT = MC_LATENCY - 2;

    logic [MC_LATENCY-1:0] slot_valid;
    logic [REG_BITS-1:0]   slot_dest [MC_LATENCY];
    logic                  sc_valid;
    logic [REG_BITS-1:0]   sc_dest;
    logic                  hazard;
    logic                  wb_conflict;
    logic                  accept;

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < MC_LATENCY; i++) begin
            if (slot_valid[i] && (slot_dest[i] == issue_src1_i || slot_dest[i] == issue_src2_i ||
                                  slot_dest[i] == issue_dest_i))
                hazard = 1'b1;
        end
        if (sc_valid && (sc_dest == issue_src1_i || sc_dest == issue_src2_i || sc_dest == issue_dest_i))
            hazard = 1'b1;
        // An op one stage short of writeback lands on the port together with a single-cycle op issued now
        wb_conflict    = !issue_multi_i && slot_valid[CONFLICT];
        issue_ready_o  = !reset && !flush_i && !hazard && !wb_conflict;
        accept         = issue_valid_i && issue_ready_o;
        mc_operation_o = (accept && issue_multi_i) ? issue_op_i : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            slot_valid <= '0;
            sc_valid   <= 1'b0;
        end else begin
            slot_valid <= {slot_valid[MC_LATENCY-2:0], accept && issue_multi_i};
            sc_valid   <= accept && !issue_multi_i;
        end
        slot_dest[0] <= issue_dest_i;
        for (int unsigned i = 1; i < MC_LATENCY; i++)
            slot_dest[i] <= slot_dest[i-1];
        sc_dest <= issue_dest_i;
    end

    always_comb begin
        wb_valid_o      = 1'b0;
        wb_dest_o       = '0;
        wb_from_multi_o = 1'b0;
        busy_o          = 1'b0;
        if (!reset) begin
            busy_o = |slot_valid;
            if (slot_valid[TOP]) begin
                wb_valid_o      = 1'b1;
                wb_dest_o       = slot_dest[TOP];
                wb_from_multi_o = 1'b1;
            end else if (sc_valid) begin
                wb_valid_o = 1'b1;
                wb_dest_o  = sc_dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(slot_valid[TOP] && sc_valid));
    end

endmodule

// File: tb/tb_multi_cycle_issue_scheduler.sv
// Bench for multi_cycle_issue_scheduler: directed per-cycle vector table, then
// random traffic checked against a due-time writeback model.
module tb_multi_cycle_issue_scheduler;

    localparam int MC = 3;

    logic       clk = 1'b0;
    logic       reset, flush_i, issue_valid_i, issue_multi_i;
    logic [5:0] issue_op_i;
    logic [4:0] issue_dest_i, issue_src1_i, issue_src2_i;
    logic       issue_ready_o, wb_valid_o, wb_from_multi_o, busy_o;
    logic [5:0] mc_operation_o;
    logic [4:0] wb_dest_o;

    int vectors = 0;
    int miscompares = 0;

    multi_cycle_issue_scheduler #(.MC_LATENCY(3), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_multi_i(issue_multi_i),
        .issue_op_i(issue_op_i), .issue_dest_i(issue_dest_i),
        .issue_src1_i(issue_src1_i), .issue_src2_i(issue_src2_i),
        .issue_ready_o(issue_ready_o), .mc_operation_o(mc_operation_o),
        .wb_valid_o(wb_valid_o), .wb_dest_o(wb_dest_o),
        .wb_from_multi_o(wb_from_multi_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // expected packing: {ready, mc_op[5:0], wb_valid, wb_dest[4:0], wb_from_multi, busy}
    typedef struct {
        logic rst, flush, valid, multi;
        logic [5:0] op;
        logic [4:0] dest, src1, src2;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0] dest;
        int         due;
        logic       multi;
    } rec_t;

    vec_t tbl[$];
    rec_t q[$];
    int   t = 0;

    function automatic vec_t mk(input logic rst, input logic flush, input logic valid, input logic multi,
                                input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic rdy, input logic [5:0] mc,
                                input logic wbv, input logic [4:0] wbd, input logic wbm, input logic busy);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.multi = multi;
        v.op = op; v.dest = d; v.src1 = s1; v.src2 = s2;
        v.exp = {rdy, mc, wbv, wbd, wbm, busy};
        return v;
    endfunction

    // idle cycle: nothing valid, fields point at r0 which the tests never write
    function automatic vec_t idle(input logic rdy, input logic wbv, input logic [4:0] wbd,
                                  input logic wbm, input logic busy);
        return mk(0, 0, 0, 1, 6'd0, 5'd0, 5'd0, 5'd0, rdy, 6'd0, wbv, wbd, wbm, busy);
    endfunction

    // Reference: every in-flight op is a record of (dest, cycle it writes back)
    function automatic logic [14:0] model(input vec_t v, output logic acc);
        logic haz, conf, rdy, wbv, wbm, busy;
        logic [4:0] wbd;
        haz = 0; conf = 0; wbv = 0; wbm = 0; busy = 0; wbd = '0;
        foreach (q[i]) begin
            if (q[i].due >= t && (q[i].dest == v.dest || q[i].dest == v.src1 || q[i].dest == v.src2))
                haz = 1;
            if (q[i].multi && q[i].due == t + 1) conf = 1;
            if (q[i].multi && q[i].due >= t) busy = 1;
            if (q[i].due == t && (!wbv || q[i].multi)) begin
                wbv = 1; wbd = q[i].dest; wbm = q[i].multi;
            end
        end
        rdy = !v.rst && !v.flush && !haz && !(conf && !v.multi);
        acc = v.valid && rdy;
        if (v.rst) return '0;
        return {rdy, (acc && v.multi) ? v.op : 6'd0, wbv, wbd, wbm, busy};
    endfunction

    function automatic void model_step(input vec_t v, input logic acc);
        rec_t keep[$];
        rec_t r;
        if (!v.rst && !v.flush)
            foreach (q[i]) if (q[i].due > t) keep.push_back(q[i]);
        if (acc) begin
            r.dest = v.dest; r.multi = v.multi; r.due = v.multi ? t + MC : t + 1;
            keep.push_back(r);
        end
        q = keep;
        t++;
    endfunction

    task automatic apply(input vec_t v, input bit use_model, input string name);
        logic [14:0] got, exp_m, exp;
        logic acc;
        reset = v.rst; flush_i = v.flush; issue_valid_i = v.valid; issue_multi_i = v.multi;
        issue_op_i = v.op; issue_dest_i = v.dest; issue_src1_i = v.src1; issue_src2_i = v.src2;
        @(negedge clk);
        exp_m = model(v, acc);
        exp = use_model ? exp_m : v.exp;
        got = {issue_ready_o, mc_operation_o, wb_valid_o, wb_dest_o, wb_from_multi_o, busy_o};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got rdy=%b mc=%0d wbv=%b wbd=%0d wbm=%b busy=%b, required rdy=%b mc=%0d wbv=%b wbd=%0d wbm=%b busy=%b",
                     name, t, got[14], got[13:8], got[7], got[6:2], got[1], got[0],
                     exp[14], exp[13:8], exp[7], exp[6:2], exp[1], exp[0]);
        end
        @(posedge clk);
        model_step(v, acc);
        #1;
    endtask

    initial begin
        // reset, then idle
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // multi FMUL to r5
        tbl.push_back(mk(0, 0, 1, 1, 6'd12, 5, 1, 2,  1, 6'd12, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 1));
        tbl.push_back(idle(1, 0, 0, 0, 1));
        tbl.push_back(idle(1, 1, 5, 1, 1));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // multi r5, then single reading r5 held valid
        tbl.push_back(mk(0, 0, 1, 1, 6'd3, 5, 1, 2,  1, 6'd3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 6'd1, 6, 5, 2,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd1, 6, 5, 2,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd1, 6, 5, 2,  0, 0, 1, 5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd1, 6, 5, 2,  1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 1, 6, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // multi r7, independent single blocked by writeback port
        tbl.push_back(mk(0, 0, 1, 1, 6'd4, 7, 1, 2,  1, 6'd4, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd2, 8, 3, 4,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd2, 8, 3, 4,  1, 0, 1, 7, 1, 1));
        tbl.push_back(idle(1, 1, 8, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // four back-to-back multi ops
        tbl.push_back(mk(0, 0, 1, 1, 6'd5, 1, 10, 11,  1, 6'd5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 6'd6, 2, 10, 11,  1, 6'd6, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 6'd7, 3, 10, 11,  1, 6'd7, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 6'd8, 4, 10, 11,  1, 6'd8, 1, 1, 1, 1));
        tbl.push_back(idle(1, 1, 2, 1, 1));
        tbl.push_back(idle(1, 1, 3, 1, 1));
        tbl.push_back(idle(1, 1, 4, 1, 1));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // multi r9 flushed; r9 no longer blocks
        tbl.push_back(mk(0, 0, 1, 1, 6'd9, 9, 1, 2,  1, 6'd9, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'd0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 6'd1, 10, 9, 2,  1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 1, 10, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("table_row%0d", i));

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v.rst   = ($urandom_range(0, 59) == 0);
            v.flush = ($urandom_range(0, 24) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.multi = $urandom_range(0, 1);
            v.op    = 6'($urandom_range(1, 63));
            v.dest  = 5'($urandom_range(0, 7));
            v.src1  = 5'($urandom_range(0, 7));
            v.src2  = 5'($urandom_range(0, 7));
            v.exp   = '0;
            apply(v, 1'b1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
